// File: rtl/imem_loader.sv
// imem_loader: turns a little-endian byte stream (LEN_LO, LEN_HI, N words) into imem word writes
// and holds the core until the image is complete. Define IMEM_LOADER_CKSUM_EN for a trailing XOR checksum byte.
module imem_loader #(
    parameter  int ROM_SIZE = 512,
    localparam int ADDR_W   = $clog2(ROM_SIZE)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_ready,
    input  logic              i_reload,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [31:0]       o_wr_data,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_error,
    output logic [2:0]        o_dbg_state
);
    // rx handshake: a byte moves on every posedge where i_rx_valid and o_rx_ready are both high;
    // o_rx_ready is registered from the next state, so it never depends on i_rx_valid combinationally.
    typedef enum logic [2:0] {
        S_LEN0  = 3'd0,
        S_LEN1  = 3'd1,
        S_DATA  = 3'd2,
`ifdef IMEM_LOADER_CKSUM_EN
        S_CHK   = 3'd3,
`endif
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t            r_state, w_state_nx;
    logic [15:0]       r_len, w_len_nx;
    logic [1:0]        r_byte_cnt, w_byte_cnt_nx;
    logic [ADDR_W-1:0] r_word_idx, w_word_idx_nx;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nx;
    logic [31:0]       r_wr_data, w_wr_data_nx;
    logic              r_wr_en, w_wr_en_nx;
    logic              r_rx_ready, w_rx_ready_nx;
    logic              r_cpu_hold, r_done, r_error;
    logic              w_xfer, w_last_word;
    logic [15:0]       w_len_full;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]        r_cksum, w_cksum_nx;
`endif

    assign w_xfer      = i_rx_valid & r_rx_ready;
    assign w_len_full  = {i_rx_data, r_len[7:0]};
    assign w_last_word = (32'(r_word_idx) + 32'd1) == 32'(r_len);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_LEN0;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_len_nx      = r_len;
        w_byte_cnt_nx = r_byte_cnt;
        w_word_idx_nx = r_word_idx;
        w_wr_addr_nx  = r_wr_addr;
        w_wr_data_nx  = r_wr_data;
        w_wr_en_nx    = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
        w_cksum_nx    = r_cksum;
`endif
        case (r_state)
            S_LEN0: begin
                if (w_xfer) begin
                    w_len_nx[7:0] = i_rx_data;
                    w_state_nx    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (w_xfer) begin
                    w_len_nx = w_len_full;
                    if (w_len_full == 16'd0 || 32'(w_len_full) > ROM_SIZE) begin
                        w_state_nx = S_ERROR;
                    end else begin
                        w_state_nx = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    w_wr_data_nx[{r_byte_cnt, 3'b000} +: 8] = i_rx_data;
                    w_byte_cnt_nx = r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
                    w_cksum_nx    = r_cksum ^ i_rx_data;
`endif
                    // Fourth byte completes the word: the write strobe and the state change land on the same edge.
                    if (r_byte_cnt == 2'd3) begin
                        w_wr_en_nx    = 1'b1;
                        w_wr_addr_nx  = r_word_idx;
                        w_word_idx_nx = r_word_idx + ADDR_W'(1);
                        if (w_last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
                            w_state_nx = S_CHK;
`else
                            w_state_nx = S_DONE;
`endif
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CKSUM_EN
            S_CHK: begin
                if (w_xfer) begin
                    w_state_nx = (i_rx_data == r_cksum) ? S_DONE : S_ERROR;
                end
            end
`endif
            S_DONE, S_ERROR: begin
                if (i_reload) begin
                    w_state_nx    = S_LEN0;
                    w_len_nx      = 16'd0;
                    w_byte_cnt_nx = 2'd0;
                    w_word_idx_nx = '0;
`ifdef IMEM_LOADER_CKSUM_EN
                    w_cksum_nx    = 8'd0;
`endif
                end
            end
            default: begin
                w_state_nx = S_LEN0;
            end
        endcase
        w_rx_ready_nx = !(w_state_nx == S_DONE || w_state_nx == S_ERROR);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_len      <= 16'd0;
            r_byte_cnt <= 2'd0;
            r_word_idx <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= 32'd0;
            r_wr_en    <= 1'b0;
            r_rx_ready <= 1'b1;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            r_cksum    <= 8'd0;
`endif
        end else begin
            r_len      <= w_len_nx;
            r_byte_cnt <= w_byte_cnt_nx;
            r_word_idx <= w_word_idx_nx;
            r_wr_addr  <= w_wr_addr_nx;
            r_wr_data  <= w_wr_data_nx;
            r_wr_en    <= w_wr_en_nx;
            r_rx_ready <= w_rx_ready_nx;
            r_cpu_hold <= (w_state_nx != S_DONE);
            r_done     <= (w_state_nx == S_DONE);
            r_error    <= (w_state_nx == S_ERROR);
`ifdef IMEM_LOADER_CKSUM_EN
            r_cksum    <= w_cksum_nx;
`endif
        end
    end

    assign o_rx_ready  = r_rx_ready;
    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_cpu_hold  = r_cpu_hold;
    assign o_done      = r_done;
    assign o_error     = r_error;
    assign o_dbg_state = r_state;

endmodule
